// File: rtl/wb_multi_adapter.sv
// Multi-channel memory-request arbiter onto a pipelined Wishbone B4 master.
// One transaction in flight; fixed or round-robin grant; optional watchdog.
module wb_multi_adapter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 0,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            mem_read,
  input  logic [NUM_PORTS-1:0]            mem_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_addr,
  input  logic [NUM_PORTS*SEL_WIDTH-1:0]  mem_byte_en,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [NUM_PORTS-1:0]            mem_ready,
  output logic [NUM_PORTS-1:0]            mem_err,
  output logic                            wb_cyc_o,
  output logic                            wb_stb_o,
  input  logic                            wb_stall_i,
  output logic                            wb_we_o,
  output logic [ADDR_WIDTH-1:0]           wb_adr_o,
  output logic [SEL_WIDTH-1:0]            wb_sel_o,
  output logic [DATA_WIDTH-1:0]           wb_dat_o,
  input  logic [DATA_WIDTH-1:0]           wb_dat_i,
  input  logic                            wb_ack_i,
  input  logic                            wb_err_i
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         gnt_q, gnt_d, last_q, last_d, pick;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d, eflag_q, eflag_d;
  logic                  cyc_q, cyc_d, stb_q, stb_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d, rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]  req, rdy_q, rdy_d, err_q, err_d;
  logic                  fin, expired;

  assign req = mem_read | mem_write;

  // Round-robin search starts one past the last grant and wraps.
  always_comb begin : arb
    int idx;
    pick = '0;
    idx  = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--)
        if (req[i]) pick = IW'(i);
    end else begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        idx = int'(last_q) + 1 + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (req[idx]) pick = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = '0;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    eflag_d = eflag_q;
    rdata_d = rdata_q;
    fin     = 1'b0;
    expired = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          last_d  = pick;
          we_d    = mem_write[pick];
          adr_d   = mem_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          sel_d   = mem_byte_en[pick*SEL_WIDTH +: SEL_WIDTH];
          dat_d   = mem_write[pick] ?
                    mem_wdata[pick*DATA_WIDTH +: DATA_WIDTH] : '0;
          eflag_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == WAIT || !wb_stall_i) begin
          if (wb_ack_i || wb_err_i) fin = 1'b1;
          else if (state_q == REQ) state_d = WAIT;
        end
        if (fin) begin
          state_d = DONE;
          eflag_d = wb_err_i;
          if (wb_ack_i && !wb_err_i && !we_q) rdata_d = wb_dat_i;
        end else if (expired) begin
          state_d = DONE;
          eflag_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cyc_d = (state_d == REQ) || (state_d == WAIT);
    stb_d = (state_d == REQ);
    rdy_d = '0;
    err_d = '0;
    if (state_d == DONE) begin
      rdy_d[gnt_d] = 1'b1;
      err_d[gnt_d] = eflag_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_PORTS - 1);
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      eflag_q <= 1'b0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      rdy_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      eflag_q <= eflag_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;
  assign mem_rdata = rdata_q;
  assign mem_ready = rdy_q;
  assign mem_err   = err_q;
endmodule

// File: tb/tb_wb_multi_adapter.sv
// Bench for wb_multi_adapter: a fixed-priority instance with watchdog and a
// round-robin instance, checked against queued expected bus/completion records.
`timescale 1ns/1ps
module tb_wb_multi_adapter;
  typedef struct packed {
    logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat;
  } bus_t;
  typedef struct packed {
    logic [1:0] rdy; logic [1:0] err; logic [31:0] rdata;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [1:0]  a_read, a_write, a_ready, a_err;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_be;
  logic [31:0] a_rdata, a_adr, a_dato, a_dati;
  logic [3:0]  a_sel;
  logic a_cyc, a_stb, a_stall, a_we, a_ack, a_werr;

  logic [1:0]  b_read, b_write, b_ready, b_err;
  logic [63:0] b_addr, b_wdata;
  logic [7:0]  b_be;
  logic [31:0] b_rdata, b_adr, b_dato, b_dati;
  logic [3:0]  b_sel;
  logic b_cyc, b_stb, b_stall, b_we, b_ack, b_werr;

  wb_multi_adapter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                     .ARB_MODE(0), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .mem_read(a_read), .mem_write(a_write),
    .mem_addr(a_addr), .mem_byte_en(a_be), .mem_wdata(a_wdata),
    .mem_rdata(a_rdata), .mem_ready(a_ready), .mem_err(a_err),
    .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_stall_i(a_stall),
    .wb_we_o(a_we), .wb_adr_o(a_adr), .wb_sel_o(a_sel), .wb_dat_o(a_dato),
    .wb_dat_i(a_dati), .wb_ack_i(a_ack), .wb_err_i(a_werr));

  wb_multi_adapter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                     .ARB_MODE(1), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .mem_read(b_read), .mem_write(b_write),
    .mem_addr(b_addr), .mem_byte_en(b_be), .mem_wdata(b_wdata),
    .mem_rdata(b_rdata), .mem_ready(b_ready), .mem_err(b_err),
    .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_stall_i(b_stall),
    .wb_we_o(b_we), .wb_adr_o(b_adr), .wb_sel_o(b_sel), .wb_dat_o(b_dato),
    .wb_dat_i(b_dati), .wb_ack_i(b_ack), .wb_err_i(b_werr));

  int n_chk = 0, n_pass = 0;
  int stall_left = 0, s_mode = 0, t_req = 0;
  int stb_hi = 0, cyc_hi = 0, adr_chg = 0;
  logic [31:0] s_data = '0, exp_rd = '0, adr_prev = '0;
  logic force_ack = 1'b0, a_pend = 1'b0, b_pend = 1'b0, stb_prev = 1'b0;
  bus_t  exp_bus[$], obs_bus[$];
  done_t exp_done[$], obs_done[$], exp_b[$], obs_b[$];
  int    obs_t[$];

  // Slave A: programmable stall count, then ack (mode 0), err (1) or silence (2).
  always @(posedge clk) begin
    #1;
    a_ack  = force_ack;
    a_werr = 1'b0;
    a_stall = 1'b0;
    if (a_pend) begin
      a_pend = 1'b0;
      if (a_cyc && s_mode == 0) begin a_ack = 1'b1; a_dati = s_data; end
      else if (a_cyc && s_mode == 1) a_werr = 1'b1;
    end
    if (a_cyc && a_stb) begin
      if (stall_left > 0) begin a_stall = 1'b1; stall_left--; end
      else a_pend = 1'b1;
    end
  end

  // Slave B: never stalls, acks the cycle after stb with an address tag.
  always @(posedge clk) begin
    #1;
    b_ack = b_pend && b_cyc;
    if (b_ack) b_dati = {16'hB0B0, b_adr[15:0]};
    b_pend = b_cyc && b_stb;
  end

  always @(negedge clk) begin
    if (a_stb) begin
      stb_hi++;
      if (stb_prev && a_adr !== adr_prev) adr_chg++;
    end
    if (a_cyc) cyc_hi++;
    stb_prev = a_stb;
    adr_prev = a_adr;
    if (a_cyc && a_stb && !a_stall)
      obs_bus.push_back('{a_adr, a_we, a_sel, a_dato});
    if (a_ready != 2'b00) begin
      obs_done.push_back('{a_ready, a_err, a_rdata});
      obs_t.push_back(cyc_n);
    end
    if (b_ready != 2'b00) obs_b.push_back('{b_ready, b_err, b_rdata});
  end

  task automatic clear();
    exp_bus.delete(); obs_bus.delete(); exp_done.delete();
    obs_done.delete(); obs_t.delete(); exp_b.delete(); obs_b.delete();
    stb_hi = 0; cyc_hi = 0; adr_chg = 0;
  endtask

  task automatic a_issue(input int ch, input logic rd, input logic wr,
                         input logic [31:0] ad, input logic [3:0] be,
                         input logic [31:0] wd);
    a_read[ch] = rd;
    a_write[ch] = wr;
    a_addr[ch*32 +: 32] = ad;
    a_be[ch*4 +: 4] = be;
    a_wdata[ch*32 +: 32] = wd;
  endtask

  // Drops each channel's request when its ready is seen; ok=0 on budget expiry.
  task automatic a_run(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++)
        if (a_ready[c]) begin a_read[c] = 1'b0; a_write[c] = 1'b0; end
      if (a_read == 2'b00 && a_write == 2'b00 && !a_cyc) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_cyc, a_stb, a_we} !== 3'b000)
      $display("FAIL reset_ctl: got %b want 000", {a_cyc, a_stb, a_we});
    else n_pass++;
    n_chk++;
    if ({a_ready, a_err, b_ready, b_err} !== 8'h00)
      $display("FAIL reset_rdy: got %h want 00", {a_ready, a_err, b_ready, b_err});
    else n_pass++;
    n_chk++;
    if ({a_adr, a_sel, a_dato, a_rdata} !== 100'h0)
      $display("FAIL reset_bus: got %h want 0", {a_adr, a_sel, a_dato, a_rdata});
    else n_pass++;
    n_chk++;
    if ({b_cyc, b_stb} !== 2'b00)
      $display("FAIL reset_b_ctl: got %b want 00", {b_cyc, b_stb});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read();
    bit ok; int lat; bus_t eb; done_t ed;
    clear();
    s_mode = 0; s_data = 32'hDEADBEEF;
    @(negedge clk);
    a_issue(1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
    t_req = cyc_n;
    exp_bus.push_back('{32'h100, 1'b0, 4'hF, 32'h0});
    exp_done.push_back('{2'b10, 2'b00, 32'hDEADBEEF});
    exp_rd = 32'hDEADBEEF;
    a_run(20, ok);
    n_chk++;
    if (!ok) $display("FAIL rd_finish: got timeout want done"); else n_pass++;
    // Counted inclusively from the sampling IDLE cycle to the DONE cycle.
    lat = (obs_t.size() > 0) ? obs_t[0] - t_req + 1 : -1;
    n_chk++;
    if (lat !== 4) $display("FAIL rd_latency: got %0d want 4", lat); else n_pass++;
    n_chk++;
    if (stb_hi !== 1) $display("FAIL rd_stb_len: got %0d want 1", stb_hi); else n_pass++;
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front();
      n_chk++;
      if (obs_bus.size() == 0) $display("FAIL rd_bus: got none want %h", eb);
      else if (obs_bus[0] !== eb) $display("FAIL rd_bus: got %h want %h", obs_bus.pop_front(), eb);
      else begin void'(obs_bus.pop_front()); n_pass++; end
    end
    while (exp_done.size() > 0) begin
      ed = exp_done.pop_front();
      n_chk++;
      if (obs_done.size() == 0) $display("FAIL rd_done: got none want %h", ed);
      else if (obs_done[0] !== ed) $display("FAIL rd_done: got %h want %h", obs_done.pop_front(), ed);
      else begin void'(obs_done.pop_front()); n_pass++; end
    end
  endtask

  task automatic test_fixed_priority();
    bit ok; bus_t eb; done_t ed;
    clear();
    s_mode = 0; s_data = 32'hCAFEF00D;
    @(negedge clk);
    a_issue(0, 1'b0, 1'b1, 32'h200, 4'b0011, 32'h12345678);
    a_issue(1, 1'b1, 1'b0, 32'h104, 4'hF, 32'h0);
    exp_bus.push_back('{32'h200, 1'b1, 4'b0011, 32'h12345678});
    exp_bus.push_back('{32'h104, 1'b0, 4'hF, 32'h0});
    exp_done.push_back('{2'b01, 2'b00, exp_rd});
    exp_done.push_back('{2'b10, 2'b00, 32'hCAFEF00D});
    exp_rd = 32'hCAFEF00D;
    a_run(30, ok);
    n_chk++;
    if (!ok) $display("FAIL fix_finish: got timeout want done"); else n_pass++;
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front();
      n_chk++;
      if (obs_bus.size() == 0) $display("FAIL fix_bus: got none want %h", eb);
      else if (obs_bus[0] !== eb) $display("FAIL fix_bus: got %h want %h", obs_bus.pop_front(), eb);
      else begin void'(obs_bus.pop_front()); n_pass++; end
    end
    while (exp_done.size() > 0) begin
      ed = exp_done.pop_front();
      n_chk++;
      if (obs_done.size() == 0) $display("FAIL fix_done: got none want %h", ed);
      else if (obs_done[0] !== ed) $display("FAIL fix_done: got %h want %h", obs_done.pop_front(), ed);
      else begin void'(obs_done.pop_front()); n_pass++; end
    end
  endtask

  task automatic test_write_wins();
    bit ok; bus_t eb; done_t ed;
    clear();
    s_mode = 0; s_data = 32'h0BAD0BAD;
    @(negedge clk);
    a_issue(0, 1'b1, 1'b1, 32'h220, 4'b1100, 32'h000055AA);
    exp_bus.push_back('{32'h220, 1'b1, 4'b1100, 32'h000055AA});
    exp_done.push_back('{2'b01, 2'b00, exp_rd});
    a_run(20, ok);
    eb = exp_bus.pop_front();
    n_chk++;
    if (obs_bus.size() == 0) $display("FAIL ww_bus: got none want %h", eb);
    else if (obs_bus[0] !== eb) $display("FAIL ww_bus: got %h want %h", obs_bus[0], eb);
    else n_pass++;
    ed = exp_done.pop_front();
    n_chk++;
    if (obs_done.size() == 0) $display("FAIL ww_done: got none want %h", ed);
    else if (obs_done[0] !== ed) $display("FAIL ww_done: got %h want %h", obs_done[0], ed);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit ok; int lat; done_t ed;
    clear();
    s_mode = 0; s_data = 32'hA5A50003; stall_left = 3;
    @(negedge clk);
    a_issue(0, 1'b1, 1'b0, 32'h300, 4'b0101, 32'h0);
    t_req = cyc_n;
    exp_done.push_back('{2'b01, 2'b00, 32'hA5A50003});
    exp_rd = 32'hA5A50003;
    a_run(30, ok);
    n_chk++;
    if (stb_hi !== 4) $display("FAIL stall_stb_len: got %0d want 4", stb_hi); else n_pass++;
    n_chk++;
    if (adr_chg !== 0) $display("FAIL stall_adr_stable: got %0d changes want 0", adr_chg);
    else n_pass++;
    lat = (obs_t.size() > 0) ? obs_t[0] - t_req + 1 : -1;
    n_chk++;
    if (lat !== 7) $display("FAIL stall_latency: got %0d want 7", lat); else n_pass++;
    ed = exp_done.pop_front();
    n_chk++;
    if (obs_done.size() == 0) $display("FAIL stall_done: got none want %h", ed);
    else if (obs_done[0] !== ed) $display("FAIL stall_done: got %h want %h", obs_done[0], ed);
    else n_pass++;
  endtask

  task automatic test_bus_error();
    bit ok; done_t ed;
    clear();
    s_mode = 1; s_data = 32'h77777777;
    @(negedge clk);
    a_issue(1, 1'b1, 1'b0, 32'h180, 4'hF, 32'h0);
    exp_done.push_back('{2'b10, 2'b10, exp_rd});
    a_run(20, ok);
    n_chk++;
    if (!ok) $display("FAIL err_finish: got timeout want done"); else n_pass++;
    ed = exp_done.pop_front();
    n_chk++;
    if (obs_done.size() == 0) $display("FAIL err_done: got none want %h", ed);
    else if (obs_done[0] !== ed) $display("FAIL err_done: got %h want %h", obs_done[0], ed);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok; done_t ed;
    clear();
    s_mode = 2;
    @(negedge clk);
    a_issue(0, 1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
    exp_done.push_back('{2'b01, 2'b01, exp_rd});
    a_run(30, ok);
    n_chk++;
    if (cyc_hi !== 8) $display("FAIL wdog_cyc_len: got %0d want 8", cyc_hi); else n_pass++;
    ed = exp_done.pop_front();
    n_chk++;
    if (obs_done.size() == 0) $display("FAIL wdog_done: got none want %h", ed);
    else if (obs_done[0] !== ed) $display("FAIL wdog_done: got %h want %h", obs_done.pop_front(), ed);
    else begin void'(obs_done.pop_front()); n_pass++; end
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (obs_done.size() != 0 || a_cyc !== 1'b0)
      $display("FAIL late_ack: got %0d readies cyc=%b want 0 readies cyc=0", obs_done.size(), a_cyc);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok; int n; done_t ed;
    clear();
    exp_b.push_back('{2'b01, 2'b00, 32'hB0B00010});
    exp_b.push_back('{2'b10, 2'b00, 32'hB0B00020});
    exp_b.push_back('{2'b01, 2'b00, 32'hB0B00010});
    exp_b.push_back('{2'b10, 2'b00, 32'hB0B00020});
    @(negedge clk);
    b_addr = {32'h20, 32'h10};
    b_read = 2'b11;
    n = 0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_ready != 2'b00) n++;
      if (n == 4) begin b_read = 2'b00; ok = 1'b1; break; end
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (!ok) $display("FAIL rr_finish: got %0d grants want 4", n); else n_pass++;
    while (exp_b.size() > 0) begin
      ed = exp_b.pop_front();
      n_chk++;
      if (obs_b.size() == 0) $display("FAIL rr_grant: got none want %h", ed);
      else if (obs_b[0] !== ed) $display("FAIL rr_grant: got %h want %h", obs_b.pop_front(), ed);
      else begin void'(obs_b.pop_front()); n_pass++; end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    clear();
    s_mode = 2;
    @(negedge clk);
    a_issue(1, 1'b1, 1'b0, 32'h1C0, 4'hF, 32'h0);
    hit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_cyc && !a_stb) begin hit = 1'b1; break; end
    end
    n_chk++;
    if (!hit) $display("FAIL rstmid_wait: got no WAIT phase want one"); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({a_cyc, a_stb, a_ready} !== 4'b0000)
      $display("FAIL rstmid_async: got %b want 0000", {a_cyc, a_stb, a_ready});
    else n_pass++;
    a_read = 2'b00;
    a_write = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_chk++;
    if (obs_done.size() != 0)
      $display("FAIL rstmid_noready: got %0d readies want 0", obs_done.size());
    else n_pass++;
    n_chk++;
    if ({a_cyc, a_rdata} !== 33'h0)
      $display("FAIL rstmid_idle: got %h want 0", {a_cyc, a_rdata});
    else n_pass++;
  endtask

  initial begin
    a_read = '0; a_write = '0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_read = '0; b_write = '0; b_addr = '0; b_be = 8'hFF; b_wdata = '0;
    a_stall = 1'b0; a_ack = 1'b0; a_werr = 1'b0; a_dati = '0;
    b_stall = 1'b0; b_ack = 1'b0; b_werr = 1'b0; b_dati = '0;
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_write_wins();
    test_stall();
    test_bus_error();
    test_timeout();
    test_round_robin();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
